// File: rtl/mdu_iter_pkg.sv
// mdu_iter shared definitions.
// Op and state encodings plus small op decode helpers.
package mdu_iter_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mdu_st_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring division step on a {rem, quo} pair.
// Shifts the pair left, trial-subtracts the divisor, sets the quotient bit.
module mdu_iter_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] quo_i,
   input  logic [W-1:0] dvs_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] quo_o
);

   logic [W:0] rem_sh;
   logic [W:0] diff;

   // shift, trial subtract, restore on borrow
   always_comb begin
      rem_sh = {rem_i, quo_i[W-1]};
      diff   = rem_sh - {1'b0, dvs_i};
      rem_o  = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
      quo_o  = {quo_i[W-2:0], ~diff[W]};
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit producing the {hi, lo} pair.
// Radix-2 shift-add multiply and restoring divide, with annul and stall.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int W        = 32,
   parameter bit MUL_ITER = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           annul,
   output logic           ready,
   output logic           stall,
   output logic           busy,
   output logic [2*W-1:0] hilo_out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

   mdu_st_e        st_q;
   logic [CW-1:0]  cnt_q;
   logic           div_q;
   logic           sa_q;
   logic           sb_q;
   logic [W-1:0]   ma_q;
   logic [W-1:0]   mb_q;
   logic [2*W-1:0] acc_q;
   logic [2*W-1:0] hilo_q;
   logic           ready_q;

   logic           sa_d;
   logic           sb_d;
   logic [W-1:0]   ma_d;
   logic [W-1:0]   mb_d;
   logic [2*W-1:0] fast_p;
   logic [2*W-1:0] fast_d;
   logic [W-1:0]   div_rem_d;
   logic [W-1:0]   div_quo_d;
   logic [W:0]     mul_sum_d;
   logic [2*W-1:0] calc_d;
   logic [W-1:0]   quo_f;
   logic [W-1:0]   rem_f;
   logic [2*W-1:0] prod_f;
   logic [2*W-1:0] fix_d;

   // operand signs and magnitudes at acceptance
   always_comb begin
      sa_d   = op_is_signed(op) & a[W-1];
      sb_d   = op_is_signed(op) & b[W-1];
      ma_d   = sa_d ? -a : a;
      mb_d   = sb_d ? -b : b;
      fast_p = {{W{1'b0}}, ma_d} * {{W{1'b0}}, mb_d};
      fast_d = (sa_d ^ sb_d) ? -fast_p : fast_p;
   end

   mdu_iter_div_step #(.W(W)) u_div_step (
      .rem_i (acc_q[2*W-1:W]),
      .quo_i (acc_q[W-1:0]),
      .dvs_i (mb_q),
      .rem_o (div_rem_d),
      .quo_o (div_quo_d)
   );

   // one shift-add or restoring step, then sign fix of the result
   always_comb begin
      mul_sum_d = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, ma_q} : '0);
      calc_d    = div_q ? {div_rem_d, div_quo_d}
                        : {mul_sum_d, acc_q[W-1:1]};
      quo_f     = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem_f     = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      prod_f    = (sa_q ^ sb_q) ? -acc_q : acc_q;
      fix_d     = div_q ? {rem_f, quo_f} : prod_f;
   end

   // control FSM with registered result and ready
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ma_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         hilo_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         unique case (st_q)
            ST_IDLE: begin
               if (start && !annul) begin
                  div_q <= op_is_div(op);
                  sa_q  <= sa_d;
                  sb_q  <= sb_d;
                  ma_q  <= ma_d;
                  mb_q  <= mb_d;
                  cnt_q <= CNT_MAX;
                  acc_q <= op_is_div(op) ? {{W{1'b0}}, ma_d}
                                         : {{W{1'b0}}, mb_d};
                  if (op_is_div(op) && (b == '0)) begin
                     hilo_q  <= {a, {W{1'b1}}};
                     ready_q <= 1'b1;
                     st_q    <= ST_DONE;
                  end else if (!op_is_div(op) && !MUL_ITER) begin
                     hilo_q  <= fast_d;
                     ready_q <= 1'b1;
                     st_q    <= ST_DONE;
                  end else begin
                     st_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (annul) begin
                  st_q <= ST_IDLE;
               end else begin
                  acc_q <= calc_d;
                  if (cnt_q == '0) begin
                     st_q <= ST_FIX;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            ST_FIX: begin
               if (annul) begin
                  st_q <= ST_IDLE;
               end else begin
                  hilo_q  <= fix_d;
                  ready_q <= 1'b1;
                  st_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               st_q <= ST_IDLE;
            end
            default: begin
               st_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready    = ready_q & ~annul;
   assign stall    = start & ~ready;
   assign busy     = (st_q == ST_CALC) || (st_q == ST_FIX);
   assign hilo_out = hilo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter.
// Directed vector table plus annul, reset and idle corner sequences.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1;
   logic        start0;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        annul;
   logic        ready1, stall1, busy1;
   logic        ready0, stall0, busy0;
   logic [63:0] hilo1, hilo0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mdu_iter #(.W(32), .MUL_ITER(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .op       (op),
      .a        (a),
      .b        (b),
      .annul    (annul),
      .ready    (ready1),
      .stall    (stall1),
      .busy     (busy1),
      .hilo_out (hilo1)
   );

   mdu_iter #(.W(32), .MUL_ITER(1'b0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .start    (start0),
      .op       (op),
      .a        (a),
      .b        (b),
      .annul    (annul),
      .ready    (ready0),
      .stall    (stall0),
      .busy     (busy0),
      .hilo_out (hilo0)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          fast;
      logic [63:0] exp;
      int          lat;
      string       nm;
   } vec_t;

   vec_t v[14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // caller sits just after a posedge; start is driven here
   task automatic run(input vec_t t);
      int   lat = 0;
      int   sc  = 0;
      logic r, s;
      op = t.op;
      a  = t.a;
      b  = t.b;
      if (t.fast) start0 = 1'b1;
      else        start1 = 1'b1;
      #1;
      chk({t.nm, " stall_on"}, 64'(t.fast ? stall0 : stall1), 64'd1);
      while (1) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            a = ~t.a;
            b = t.b + 32'd1;
         end
         r = t.fast ? ready0 : ready1;
         s = t.fast ? stall0 : stall1;
         if (r) break;
         if (s) sc++;
         if (lat > 200) break;
      end
      start0 = 1'b0;
      start1 = 1'b0;
      chk({t.nm, " latency"}, 64'(lat), 64'(t.lat));
      chk({t.nm, " stall_cycles"}, 64'(sc), 64'(t.lat - 1));
      chk({t.nm, " hilo"}, t.fast ? hilo0 : hilo1, t.exp);
      @(posedge clk);
      #1;
      chk({t.nm, " ready_pulse"},
          64'(t.fast ? ready0 : ready1), 64'd0);
   endtask

   initial begin
      int   lat;
      logic any_rdy;

      v[0]  = '{MDU_DIVU,  32'd100,        32'd7,
                1'b0, {32'd2, 32'd14}, 34, "divu_100_7"};
      v[1]  = '{MDU_DIV,   32'hFFFFFFF9,   32'd2,
                1'b0, 64'hFFFFFFFF_FFFFFFFD, 34, "div_m7_2"};
      v[2]  = '{MDU_DIV,   32'h80000000,   32'hFFFFFFFF,
                1'b0, 64'h00000000_80000000, 34, "div_ovf"};
      v[3]  = '{MDU_MULT,  32'hFFFFFFFD,   32'd5,
                1'b0, 64'hFFFFFFFF_FFFFFFF1, 34, "mult_it"};
      v[4]  = '{MDU_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,
                1'b0, 64'hFFFFFFFE_00000001, 34, "multu_it"};
      v[5]  = '{MDU_MULT,  32'hFFFFFFFD,   32'd5,
                1'b1, 64'hFFFFFFFF_FFFFFFF1, 1, "mult_fast"};
      v[6]  = '{MDU_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF,
                1'b1, 64'hFFFFFFFE_00000001, 1, "multu_fast"};
      v[7]  = '{MDU_DIV,   32'h12345678,   32'd0,
                1'b0, 64'h12345678_FFFFFFFF, 1, "div_by0"};
      v[8]  = '{MDU_DIV,   32'd7,          32'hFFFFFFFE,
                1'b0, 64'h00000001_FFFFFFFD, 34, "div_7_m2"};
      v[9]  = '{MDU_DIVU,  32'hFFFFFFFF,   32'd1,
                1'b0, 64'h00000000_FFFFFFFF, 34, "divu_max_1"};
      v[10] = '{MDU_MULT,  32'h80000000,   32'h80000000,
                1'b0, 64'h40000000_00000000, 34, "mult_min_sq"};
      v[11] = '{MDU_DIV,   32'hFFFFFF9C,   32'hFFFFFFF9,
                1'b0, 64'hFFFFFFFE_0000000E, 34, "div_m100_m7"};
      v[12] = '{MDU_MULTU, 32'h00010000,   32'h00010000,
                1'b0, 64'h00000001_00000000, 34, "multu_carry"};
      v[13] = '{MDU_DIVU,  32'd5,          32'd7,
                1'b0, 64'h00000005_00000000, 34, "divu_small"};

      rst    = 1'b1;
      start1 = 1'b0;
      start0 = 1'b0;
      annul  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 64'(ready1), 64'd0);
      chk("reset busy", 64'(busy1), 64'd0);
      chk("reset hilo", hilo1, 64'd0);
      chk("reset stall", 64'(stall1), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) run(v[i]);

      // annul mid-CALC, then restart right away
      run(v[0]);
      op     = MDU_DIVU;
      a      = 32'd1000;
      b      = 32'd3;
      start1 = 1'b1;
      any_rdy = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         any_rdy |= ready1;
      end
      annul = 1'b1;
      #1;
      chk("annul busy_before", 64'(busy1), 64'd1);
      chk("annul ready_same", 64'(ready1), 64'd0);
      @(posedge clk);
      #1;
      any_rdy |= ready1;
      chk("annul no_ready", 64'(any_rdy), 64'd0);
      chk("annul busy_after", 64'(busy1), 64'd0);
      chk("annul hilo_kept", hilo1, {32'd2, 32'd14});
      annul = 1'b0;
      lat = 0;
      while (lat <= 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready1) break;
      end
      start1 = 1'b0;
      chk("restart latency", 64'(lat), 64'd34);
      chk("restart hilo", hilo1, {32'd1, 32'd333});
      @(posedge clk);
      #1;

      // annul in FIX suppresses the result write
      op     = MDU_DIVU;
      a      = 32'd50;
      b      = 32'd7;
      start1 = 1'b1;
      any_rdy = 1'b0;
      repeat (33) begin
         @(posedge clk);
         #1;
         any_rdy |= ready1;
      end
      chk("fix busy", 64'(busy1), 64'd1);
      annul  = 1'b1;
      start1 = 1'b0;
      @(posedge clk);
      #1;
      annul = 1'b0;
      any_rdy |= ready1;
      chk("fix_annul busy", 64'(busy1), 64'd0);
      @(posedge clk);
      #1;
      any_rdy |= ready1;
      chk("fix_annul no_ready", 64'(any_rdy), 64'd0);
      chk("fix_annul hilo_kept", hilo1, {32'd1, 32'd333});

      // start and annul together in IDLE
      op     = MDU_DIV;
      a      = 32'd5;
      b      = 32'd0;
      start1 = 1'b1;
      annul  = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      annul  = 1'b0;
      any_rdy = ready1;
      chk("idle_annul busy", 64'(busy1), 64'd0);
      @(posedge clk);
      #1;
      any_rdy |= ready1;
      chk("idle_annul no_ready", 64'(any_rdy), 64'd0);
      chk("idle_annul hilo", hilo1, {32'd1, 32'd333});

      // reset mid-CALC
      op     = MDU_DIVU;
      a      = 32'd100;
      b      = 32'd7;
      start1 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("rst busy_before", 64'(busy1), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst ready", 64'(ready1), 64'd0);
      chk("rst busy", 64'(busy1), 64'd0);
      chk("rst hilo", hilo1, 64'd0);
      chk("rst hilo_fast", hilo0, 64'd0);
      rst    = 1'b0;
      start1 = 1'b0;
      @(posedge clk);
      #1;
      chk("rst idle", 64'(busy1), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
